// File: rtl/imm_extend_unit.sv
// rtl/imm_extend_unit.sv - immediate sign/zero/upper/branch extension behind a two-entry skid buffer
//
// Purpose
//   Accepts a raw IN_W-bit immediate and an extension mode. It extends the
//   immediate to OUT_W bits and passes the result downstream through a
//   two-entry skid buffer. The buffer is an output register (OR) plus a skid
//   register (SR). Results leave in the order they were accepted.
//
// Parameters
//   IN_W   immediate input width (default 16)
//   OUT_W  extended output width (default 32); must satisfy OUT_W >= IN_W+2
//
// Ports
//   clk        in   1      sole clock, rising edge
//   rst        in   1      synchronous active-high reset
//   in_valid   in   1      upstream presents an immediate
//   in_ready   out  1      unit can accept an immediate (registered)
//   in_imm     in   IN_W   raw immediate field
//   in_mode    in   2      0 SIGN, 1 ZERO, 2 UPPER, 3 BRANCH
//   out_valid  out  1      out_data holds a result
//   out_ready  in   1      downstream accepts the result
//   out_data   out  OUT_W  extended immediate
//   out_neg    out  1      MSB of out_data, registered with it
//
// Configuration
//   IMM_EXTEND_BRANCH_EN  when defined, BRANCH gives the SIGN result shifted
//                         left by two. When undefined, BRANCH is the same as
//                         SIGN and the design contains no shifter.

module imm_extend_unit #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_imm,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_neg
);

  localparam int EXT_W = OUT_W - IN_W;

  localparam logic [1:0] MODE_SIGN   = 2'd0;
  localparam logic [1:0] MODE_ZERO   = 2'd1;
  localparam logic [1:0] MODE_UPPER  = 2'd2;
  localparam logic [1:0] MODE_BRANCH = 2'd3;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  // --------------------------------------------------------------------------
  // Extension datapath (combinational, evaluated on the accepting cycle)
  // --------------------------------------------------------------------------
  logic [OUT_W-1:0] w_sign;
  logic [OUT_W-1:0] w_zero;
  logic [OUT_W-1:0] w_upper;
  logic [OUT_W-1:0] w_branch;
  logic [OUT_W-1:0] w_ext;

  assign w_sign  = {{EXT_W{in_imm[IN_W-1]}}, in_imm};
  assign w_zero  = {{EXT_W{1'b0}}, in_imm};
  assign w_upper = {in_imm, {EXT_W{1'b0}}};

`ifdef IMM_EXTEND_BRANCH_EN
  // Branch offsets are word-aligned. Drop the top two bits of the
  // sign-extended value and append two zero bits.
  assign w_branch = {w_sign[OUT_W-3:0], 2'b00};
`else
  assign w_branch = w_sign;
`endif

  always_comb begin
    w_ext = w_sign;
    case (in_mode)
      MODE_SIGN:   w_ext = w_sign;
      MODE_ZERO:   w_ext = w_zero;
      MODE_UPPER:  w_ext = w_upper;
      MODE_BRANCH: w_ext = w_branch;
      default:     w_ext = w_sign;
    endcase
  end

  // --------------------------------------------------------------------------
  // Skid buffer state
  // --------------------------------------------------------------------------
  state_t           r_state;
  logic             r_in_ready;
  logic [OUT_W-1:0] r_or_data;
  logic             r_or_neg;
  logic [OUT_W-1:0] r_sr_data;

  state_t w_next_state;
  logic   w_in_xfer;
  logic   w_out_xfer;
  logic   w_load_or;   // new result goes straight into OR
  logic   w_load_sr;   // new result parks in SR behind a stalled OR
  logic   w_move_sr;   // SR advances into OR as OR drains

  assign w_in_xfer  = in_valid && r_in_ready;
  assign w_out_xfer = (r_state != S_EMPTY) && out_ready;

  always_comb begin
    w_next_state = r_state;
    w_load_or    = 1'b0;
    w_load_sr    = 1'b0;
    w_move_sr    = 1'b0;
    case (r_state)
      S_EMPTY: begin
        if (w_in_xfer) begin
          w_next_state = S_ONE;
          w_load_or    = 1'b1;
        end
      end
      S_ONE: begin
        if (w_in_xfer && !w_out_xfer) begin
          w_next_state = S_FULL;
          w_load_sr    = 1'b1;
        end else if (w_in_xfer && w_out_xfer) begin
          w_next_state = S_ONE;
          w_load_or    = 1'b1;
        end else if (w_out_xfer) begin
          w_next_state = S_EMPTY;
        end
      end
      S_FULL: begin
        // in_ready is low here, so only the drain side can move.
        if (w_out_xfer) begin
          w_next_state = S_ONE;
          w_move_sr    = 1'b1;
        end
      end
      default: begin
        w_next_state = S_EMPTY;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_EMPTY;
      r_in_ready <= 1'b1;
      r_or_data  <= '0;
      r_or_neg   <= 1'b0;
      r_sr_data  <= '0;
    end else begin
      r_state    <= w_next_state;
      // in_ready is decoded from the next state and registered. As a result
      // it never has a combinational path from out_ready.
      r_in_ready <= (w_next_state != S_FULL);
      if (w_load_or) begin
        r_or_data <= w_ext;
        r_or_neg  <= w_ext[OUT_W-1];
      end else if (w_move_sr) begin
        r_or_data <= r_sr_data;
        r_or_neg  <= r_sr_data[OUT_W-1];
      end
      if (w_load_sr) begin
        r_sr_data <= w_ext;
      end
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = (r_state != S_EMPTY);
  assign out_data  = r_or_data;
  assign out_neg   = r_or_neg;

endmodule

// File: tb/tb_imm_extend_unit.sv
// tb/tb_imm_extend_unit.sv - self-checking bench for imm_extend_unit with queue reference model
module tb_imm_extend_unit;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_imm;
  logic [1:0]  in_mode;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_neg;

  imm_extend_unit #(.IN_W(16), .OUT_W(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_imm    (in_imm),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_neg   (out_neg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference extension computed arithmetically from the mode rules.
  function automatic logic [31:0] ref_ext(input logic [15:0] imm, input logic [1:0] mode);
    longint unsigned v;
    longint unsigned s;
    s = (imm >= 16'h8000) ? (longint'(imm) + 64'hFFFF_0000) : longint'(imm);
    case (mode)
      2'd0: v = s;
      2'd1: v = longint'(imm);
      2'd2: v = longint'(imm) * 65536;
`ifdef IMM_EXTEND_BRANCH_EN
      default: v = (s * 4) % 64'h1_0000_0000;
`else
      default: v = s;
`endif
    endcase
    return v[31:0];
  endfunction

  // Model: the results held by the unit, oldest first, at most two.
  logic [31:0] pend[$];
  bit          model_live = 0;
  int          n_acc = 0;

  always @(posedge clk) begin
    bit ox;
    bit ix;
    if (rst) begin
      pend.delete();
      model_live = 1;
    end else if (model_live) begin
      ox = (pend.size() > 0) && out_ready;
      ix = in_valid && (pend.size() < 2);
      if (ox) void'(pend.pop_front());
      if (ix) begin
        pend.push_back(ref_ext(in_imm, in_mode));
        n_acc++;
      end
    end
  end

  // Every-cycle comparison against the model, plus a hold check while stalled.
  bit          stall_armed = 0;
  logic [31:0] stall_data;
  logic        stall_neg;

  always @(negedge clk) begin
    if (model_live) begin
      chk("out_valid", {31'd0, out_valid}, {31'd0, pend.size() > 0});
      chk("in_ready",  {31'd0, in_ready},  {31'd0, pend.size() < 2});
      if (pend.size() > 0) begin
        chk("out_data", out_data, pend[0]);
        chk("out_neg", {31'd0, out_neg}, {31'd0, pend[0][31]});
      end
      if (stall_armed) begin
        chk("stall_data", out_data, stall_data);
        chk("stall_neg", {31'd0, out_neg}, {31'd0, stall_neg});
      end
      stall_armed = out_valid && !out_ready && !rst;
      stall_data  = out_data;
      stall_neg   = out_neg;
    end
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic one_shot(input string name, input logic [15:0] imm, input logic [1:0] mode,
                          input logic [31:0] exp);
    in_valid = 1'b1; in_imm = imm; in_mode = mode;
    step();
    in_valid = 1'b0;
    chk({name, "_valid"}, {31'd0, out_valid}, 32'd1);
    chk({name, "_data"}, out_data, exp);
    chk({name, "_neg"}, {31'd0, out_neg}, {31'd0, exp[31]});
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int cyc;
    int target;
    rst = 1'b1; in_valid = 1'b0; in_imm = '0; in_mode = '0; out_ready = 1'b0;
    step();
    step();
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_data", out_data, 32'h0);
    chk("rst_out_neg", {31'd0, out_neg}, 32'd0);
    rst = 1'b0;
    out_ready = 1'b1;
    step();
    chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

    // Hand-computed single transactions.
    one_shot("sign_8000", 16'h8000, 2'd0, 32'hFFFF_8000);
    one_shot("zero_8000", 16'h8000, 2'd1, 32'h0000_8000);
    one_shot("upper_1234", 16'h1234, 2'd2, 32'h1234_0000);
`ifdef IMM_EXTEND_BRANCH_EN
    one_shot("branch_ffff", 16'hFFFF, 2'd3, 32'hFFFF_FFFC);
`else
    one_shot("branch_ffff", 16'hFFFF, 2'd3, 32'hFFFF_FFFF);
`endif
    one_shot("sign_7fff", 16'h7FFF, 2'd0, 32'h0000_7FFF);

    // Back-to-back while stalled: the third must wait.
    out_ready = 1'b0;
    in_valid = 1'b1; in_mode = 2'd0; in_imm = 16'h0001;
    step();
    in_imm = 16'h0002;
    step();
    in_imm = 16'h0003;
    chk("b2b_full_in_ready", {31'd0, in_ready}, 32'd0);
    step();
    step();
    chk("b2b_hold_in_ready", {31'd0, in_ready}, 32'd0);
    chk("b2b_hold_data", out_data, 32'h0000_0001);
    out_ready = 1'b1;
    step();
    chk("b2b_second", out_data, 32'h0000_0002);
    chk("b2b_ready_again", {31'd0, in_ready}, 32'd1);
    step();
    in_valid = 1'b0;
    chk("b2b_third", out_data, 32'h0000_0003);
    step();
    chk("b2b_drained", {31'd0, out_valid}, 32'd0);

    // Fill to FULL, then reset with a transfer presented in the reset cycle.
    out_ready = 1'b0;
    in_valid = 1'b1; in_mode = 2'd1; in_imm = 16'hAAAA;
    step();
    in_imm = 16'hBBBB;
    step();
    chk("full_in_ready", {31'd0, in_ready}, 32'd0);
    rst = 1'b1; in_imm = 16'hCCCC; out_ready = 1'b1;
    in_ready_force_check: begin end
    step();
    rst = 1'b0; in_valid = 1'b0;
    chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("mid_rst_out_data", out_data, 32'h0);
    step();
    step();
    chk("mid_rst_no_ghost", {31'd0, out_valid}, 32'd0);

    // Random traffic: 1000 accepted transactions checked by the model.
    target = n_acc + 1000;
    cyc = 0;
    while (n_acc < target && cyc < 20000) begin
      in_valid  = ($urandom_range(0, 99) < 60);
      out_ready = ($urandom_range(0, 99) < 55);
      in_imm    = 16'($urandom());
      in_mode   = 2'($urandom_range(0, 3));
      step();
      cyc++;
    end
    n_cmp++;
    if (n_acc < target) begin
      n_bad++;
      $display("FAIL random_budget: accepted %0d expected %0d", n_acc, target);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    step();
    step();
    chk("final_drain_valid", {31'd0, out_valid}, 32'd0);
    chk("final_model_empty", pend.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
